bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Three-master / three-slave serial bus arbiter with round-robin grant and registered outputs.
// Define BUS_ARB_TIMEOUT_EN to add an SWAIT/XFER inactivity watchdog.
module bus_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] m_req,
    input  logic [2:0] m_valid,
    input  logic [2:0] m_addr,
    input  logic [2:0] m_data,
    input  logic [2:0] m_wen,
    input  logic [2:0] m_burst,
    input  logic [2:0] s_ready,
    output logic [2:0] m_ready,
    output logic       bus_valid,
    output logic       bus_addr,
    output logic       bus_data,
    output logic       bus_wen,
    output logic       bus_burst,
    output logic [2:0] s_sel,
    output logic [1:0] grant_id,
    output logic       addr_err
);

    typedef enum logic [2:0] {IDLE, GRANT, ADDR, SWAIT, XFER, RELEASE} state_t;

    state_t     state_r, state_s;
    logic [1:0] gnt_r, gnt_s;
    logic [1:0] last_r, last_s;
    logic [1:0] sel_r, sel_s;
    logic       sel_hi_r, sel_hi_s;
    logic       err_s;
    logic       wdog_hit_s;
    logic       req_g_s, valid_g_s, addr_g_s, slave_rdy_s;
    logic [2:0] ready_s, s_sel_s, g_hot_s;
    logic [1:0] gid_s;
    logic       bus_on_s;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b000;
        endcase
    endfunction

    // Search order starts one past the previous winner.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
        logic [1:0] first, second, third;
        case (last)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
        if (|(req & onehot3(first)))       rr_pick = first;
        else if (|(req & onehot3(second))) rr_pick = second;
        else if (|(req & onehot3(third)))  rr_pick = third;
        else                               rr_pick = 2'd3;
    endfunction

    assign req_g_s     = |(m_req   & onehot3(gnt_r));
    assign valid_g_s   = |(m_valid & onehot3(gnt_r));
    assign addr_g_s    = |(m_addr  & onehot3(gnt_r));
    assign slave_rdy_s = |(s_ready & onehot3(sel_r));

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] wdog_r;
    logic       wait_state_s;

    assign wait_state_s = (state_r == SWAIT) || (state_r == XFER);
    assign wdog_hit_s   = wait_state_s && !valid_g_s && (wdog_r == 8'd254);

    // Inactivity counter: restarts on any state change or any valid bit from the owner
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_r <= 8'd0;
        end else if ((state_s != state_r) || valid_g_s || !wait_state_s) begin
            wdog_r <= 8'd0;
        end else begin
            wdog_r <= wdog_r + 8'd1;
        end
    end
`else
    assign wdog_hit_s = 1'b0;
`endif

    // Next-state and select capture
    always_comb begin
        state_s  = state_r;
        gnt_s    = gnt_r;
        last_s   = last_r;
        sel_hi_s = sel_hi_r;
        sel_s    = sel_r;
        err_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (|m_req) begin
                    state_s = GRANT;
                    gnt_s   = rr_pick(last_r, m_req);
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!req_g_s) begin
                    state_s = RELEASE;
                end else if (valid_g_s) begin
                    state_s  = ADDR;
                    sel_hi_s = addr_g_s;
                end else begin
                    state_s = GRANT;
                end
            end
            ADDR: begin
                if (!req_g_s) begin
                    state_s = RELEASE;
                end else if (valid_g_s) begin
                    if ({sel_hi_r, addr_g_s} == 2'b11) begin
                        state_s = RELEASE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = SWAIT;
                        sel_s   = {sel_hi_r, addr_g_s};
                    end
                end else begin
                    state_s = ADDR;
                end
            end
            SWAIT: begin
                if (!req_g_s) begin
                    state_s = RELEASE;
                end else if (wdog_hit_s) begin
                    state_s = RELEASE;
                    err_s   = 1'b1;
                end else if (slave_rdy_s) begin
                    state_s = XFER;
                end else begin
                    state_s = SWAIT;
                end
            end
            XFER: begin
                if (!req_g_s) begin
                    state_s = RELEASE;
                end else if (wdog_hit_s) begin
                    state_s = RELEASE;
                    err_s   = 1'b1;
                end else begin
                    state_s = XFER;
                end
            end
            RELEASE: begin
                state_s = IDLE;
                last_s  = gnt_r;
            end
            default: state_s = IDLE;
        endcase
    end

    // Output values for the state being entered, so the registered outputs track it
    always_comb begin
        ready_s  = 3'b000;
        s_sel_s  = 3'b000;
        gid_s    = 2'd3;
        bus_on_s = 1'b0;
        g_hot_s  = onehot3(gnt_s);
        case (state_s)
            GRANT, ADDR: begin
                gid_s    = gnt_s;
                ready_s  = g_hot_s;
                bus_on_s = 1'b1;
            end
            SWAIT, XFER: begin
                gid_s    = gnt_s;
                s_sel_s  = onehot3(sel_s);
                bus_on_s = 1'b1;
                if (|(s_ready & s_sel_s)) ready_s = g_hot_s;
                else                      ready_s = 3'b000;
            end
            default: bus_on_s = 1'b0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            gnt_r     <= 2'd0;
            last_r    <= 2'd2;
            sel_hi_r  <= 1'b0;
            sel_r     <= 2'd0;
            m_ready   <= 3'b000;
            s_sel     <= 3'b000;
            grant_id  <= 2'd3;
            addr_err  <= 1'b0;
            bus_valid <= 1'b0;
            bus_addr  <= 1'b0;
            bus_data  <= 1'b0;
            bus_wen   <= 1'b0;
            bus_burst <= 1'b0;
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            last_r    <= last_s;
            sel_hi_r  <= sel_hi_s;
            sel_r     <= sel_s;
            m_ready   <= ready_s;
            s_sel     <= s_sel_s;
            grant_id  <= gid_s;
            addr_err  <= err_s;
            bus_valid <= bus_on_s & |(m_valid & g_hot_s);
            bus_addr  <= bus_on_s & |(m_addr  & g_hot_s);
            bus_data  <= bus_on_s & |(m_data  & g_hot_s);
            bus_wen   <= bus_on_s & |(m_wen   & g_hot_s);
            bus_burst <= bus_on_s & |(m_burst & g_hot_s);
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter; obs packs
// {grant_id, m_ready, s_sel, addr_err, bus_valid, bus_addr, bus_data, bus_wen, bus_burst}.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] m_req, m_valid, m_addr, m_data, m_wen, m_burst, s_ready;
    logic [2:0] m_ready, s_sel;
    logic       bus_valid, bus_addr, bus_data, bus_wen, bus_burst, addr_err;
    logic [1:0] grant_id;
    logic [13:0] obs;
    int errors = 0;
    int checks = 0;

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m_req(m_req), .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data),
        .m_wen(m_wen), .m_burst(m_burst), .s_ready(s_ready),
        .m_ready(m_ready), .bus_valid(bus_valid), .bus_addr(bus_addr),
        .bus_data(bus_data), .bus_wen(bus_wen), .bus_burst(bus_burst),
        .s_sel(s_sel), .grant_id(grant_id), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    assign obs = {grant_id, m_ready, s_sel, addr_err, bus_valid, bus_addr, bus_data, bus_wen, bus_burst};

    task tick;
        @(posedge clk);
        #1;
    endtask

    task apply_reset;
        reset = 1'b0;
        m_req = 3'b000; m_valid = 3'b000; m_addr = 3'b000;
        m_data = 3'b000; m_wen = 3'b000; m_burst = 3'b000; s_ready = 3'b111;
        tick;
        tick;
        reset = 1'b1;
    endtask

    task test_reset;
        reset = 1'b0;
        m_req = 3'b111; m_valid = 3'b111; m_addr = 3'b111;
        m_data = 3'b111; m_wen = 3'b111; m_burst = 3'b111; s_ready = 3'b111;
        tick;
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL reset_hold: got %b expected %b", obs, {2'd3, 8'b0, 1'b0, 5'b0});
        end
        m_req = 3'b000;
        reset = 1'b1;
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL reset_idle: got %b expected %b", obs, {2'd3, 8'b0, 1'b0, 5'b0});
        end
    endtask

    task test_single_master;
        apply_reset;
        m_req = 3'b001;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b001, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL sm_grant: got %b expected %b", obs, {2'd0, 3'b001, 3'b000, 1'b0, 5'b00000});
        end
        m_valid = 3'b101; m_addr = 3'b000; m_data = 3'b011;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b001, 3'b000, 1'b0, 5'b10100}) begin
            errors++; $display("FAIL sm_addr1: got %b expected %b", obs, {2'd0, 3'b001, 3'b000, 1'b0, 5'b10100});
        end
        m_addr = 3'b001;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b001, 3'b010, 1'b0, 5'b11100}) begin
            errors++; $display("FAIL sm_swait: got %b expected %b", obs, {2'd0, 3'b001, 3'b010, 1'b0, 5'b11100});
        end
        m_valid = 3'b001; m_addr = 3'b000; m_data = 3'b000; m_wen = 3'b001; m_burst = 3'b001;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b001, 3'b010, 1'b0, 5'b10011}) begin
            errors++; $display("FAIL sm_xfer: got %b expected %b", obs, {2'd0, 3'b001, 3'b010, 1'b0, 5'b10011});
        end
        s_ready = 3'b101;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b000, 3'b010, 1'b0, 5'b10011}) begin
            errors++; $display("FAIL sm_backpressure: got %b expected %b", obs, {2'd0, 3'b000, 3'b010, 1'b0, 5'b10011});
        end
        s_ready = 3'b111; m_req = 3'b000; m_valid = 3'b000;
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL sm_release: got %b expected %b", obs, {2'd3, 8'b0, 1'b0, 5'b0});
        end
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL sm_idle: got %b expected %b", obs, {2'd3, 8'b0, 1'b0, 5'b0});
        end
        m_wen = 3'b000; m_burst = 3'b000;
    endtask

    task test_round_robin;
        logic [1:0] exp_g [4];
        logic [2:0] exp_r [4];
        logic       exp_d [4];
        exp_g = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_r = '{3'b001, 3'b010, 3'b100, 3'b001};
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset;
        m_req = 3'b111; m_data = 3'b010;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if (obs !== {exp_g[i], exp_r[i], 3'b000, 1'b0, 2'b00, exp_d[i], 2'b00}) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, obs, {exp_g[i], exp_r[i], 3'b000, 1'b0, 2'b00, exp_d[i], 2'b00});
            end
            m_req = 3'b111 & ~exp_r[i];
            tick;
            checks++;
            if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
                errors++; $display("FAIL rr_release%0d: got %b expected %b", i, obs, {2'd3, 8'b0, 1'b0, 5'b0});
            end
            m_req = 3'b111;
            tick;
            checks++;
            if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
                errors++; $display("FAIL rr_idle%0d: got %b expected %b", i, obs, {2'd3, 8'b0, 1'b0, 5'b0});
            end
        end
        m_req = 3'b000; m_data = 3'b000;
        tick;
        tick;
    endtask

    task test_slave_busy;
        apply_reset;
        s_ready = 3'b011; m_req = 3'b010;
        tick;
        checks++;
        if (obs !== {2'd1, 3'b010, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL sb_grant: got %b expected %b", obs, {2'd1, 3'b010, 3'b000, 1'b0, 5'b00000});
        end
        m_valid = 3'b010; m_addr = 3'b010;
        tick;
        m_valid = 3'b000; m_addr = 3'b010;
        tick;
        checks++;
        if (obs !== {2'd1, 3'b010, 3'b000, 1'b0, 5'b01000}) begin
            errors++; $display("FAIL sb_ignore_invalid_bit: got %b expected %b", obs, {2'd1, 3'b010, 3'b000, 1'b0, 5'b01000});
        end
        m_valid = 3'b010; m_addr = 3'b000;
        tick;
        checks++;
        if (obs !== {2'd1, 3'b000, 3'b100, 1'b0, 5'b10000}) begin
            errors++; $display("FAIL sb_swait: got %b expected %b", obs, {2'd1, 3'b000, 3'b100, 1'b0, 5'b10000});
        end
        m_valid = 3'b000;
        tick;
        checks++;
        if (obs !== {2'd1, 3'b000, 3'b100, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL sb_still_waiting: got %b expected %b", obs, {2'd1, 3'b000, 3'b100, 1'b0, 5'b00000});
        end
        s_ready = 3'b111;
        tick;
        checks++;
        if (obs !== {2'd1, 3'b010, 3'b100, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL sb_xfer: got %b expected %b", obs, {2'd1, 3'b010, 3'b100, 1'b0, 5'b00000});
        end
        m_req = 3'b000;
        tick;
        tick;
    endtask

    task test_invalid_select;
        apply_reset;
        m_req = 3'b100;
        tick;
        m_valid = 3'b100; m_addr = 3'b100;
        tick;
        checks++;
        if (obs !== {2'd2, 3'b100, 3'b000, 1'b0, 5'b11000}) begin
            errors++; $display("FAIL inv_addr: got %b expected %b", obs, {2'd2, 3'b100, 3'b000, 1'b0, 5'b11000});
        end
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b1, 5'b00000}) begin
            errors++; $display("FAIL inv_err_pulse: got %b expected %b", obs, {2'd3, 3'b000, 3'b000, 1'b1, 5'b00000});
        end
        m_req = 3'b000; m_valid = 3'b000; m_addr = 3'b000;
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL inv_err_cleared: got %b expected %b", obs, {2'd3, 8'b0, 1'b0, 5'b0});
        end
    endtask

    task test_reset_mid_xfer;
        apply_reset;
        m_req = 3'b001; m_valid = 3'b001; m_addr = 3'b000;
        tick;
        tick;
        tick;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b001, 3'b001, 1'b0, 5'b10000}) begin
            errors++; $display("FAIL rx_xfer: got %b expected %b", obs, {2'd0, 3'b001, 3'b001, 1'b0, 5'b10000});
        end
        repeat (4) tick;
        reset = 1'b0;
        tick;
        checks++;
        if (obs !== {2'd3, 3'b000, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL rx_abort: got %b expected %b", obs, {2'd3, 8'b0, 1'b0, 5'b0});
        end
        reset = 1'b1; m_req = 3'b010; m_valid = 3'b000;
        tick;
        checks++;
        if (obs !== {2'd1, 3'b010, 3'b000, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL rx_regrant: got %b expected %b", obs, {2'd1, 3'b010, 3'b000, 1'b0, 5'b00000});
        end
        m_req = 3'b000;
        tick;
        tick;
    endtask

    task test_watchdog;
        int  n;
        logic early;
        apply_reset;
        m_req = 3'b001; m_valid = 3'b001; m_addr = 3'b000;
        tick;
        tick;
        tick;
        m_valid = 3'b000;
        tick;
        checks++;
        if (obs !== {2'd0, 3'b001, 3'b001, 1'b0, 5'b00000}) begin
            errors++; $display("FAIL wd_xfer: got %b expected %b", obs, {2'd0, 3'b001, 3'b001, 1'b0, 5'b00000});
        end
`ifdef BUS_ARB_TIMEOUT_EN
        n = 0;
        early = 1'b0;
        while (grant_id !== 2'd3 && n < 300) begin
            if (addr_err !== 1'b0) early = 1'b1;
            tick;
            n++;
        end
        checks++;
        if (n != 255) begin
            errors++; $display("FAIL wd_timeout_cycles: got %0d expected %0d", n, 255);
        end
        checks++;
        if (addr_err !== 1'b1 || early) begin
            errors++; $display("FAIL wd_err_pulse: got %b (early %b) expected 1", addr_err, early);
        end
        m_req = 3'b000;
        tick;
        checks++;
        if (addr_err !== 1'b0) begin
            errors++; $display("FAIL wd_err_clear: got %b expected 0", addr_err);
        end
`else
        n = 0;
        early = 1'b0;
        repeat (1000) begin
            tick;
            if (grant_id !== 2'd0 || addr_err !== 1'b0) early = 1'b1;
            n++;
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL wd_held: got release within %0d cycles expected none", n);
        end
        m_req = 3'b000;
        tick;
`endif
        tick;
    endtask

    initial begin
        test_reset;
        test_single_master;
        test_round_robin;
        test_slave_busy;
        test_invalid_select;
        test_reset_mid_xfer;
        test_watchdog;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
